// File: rtl/gpp_pkg.sv
// Shared definitions for the parametrised generic packet parser (gpp_param).
package gpp_pkg;

   localparam int unsigned BEAT_W = 134;
   localparam int unsigned PAY_W  = 128;
   localparam int unsigned MD_W   = 256;
   localparam int unsigned CLS_W  = 384;

   // Beat type codes in pktin_data[133:132]
   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_BODY = 2'b11;
   localparam logic [1:0] TYPE_TAIL = 2'b10;

   localparam logic [15:0] ETH_IPV4 = 16'h0800;
   localparam logic [15:0] ETH_IPV6 = 16'h86DD;
   localparam logic [15:0] ETH_ARP  = 16'h0806;
   localparam logic [15:0] ETH_VLAN = 16'h8100;
   localparam logic [7:0]  PROTO_TCP = 8'd6;
   localparam logic [7:0]  PROTO_UDP = 8'd17;

   // Packet-type codes written into MD[79:72]
   localparam logic [7:0] PST_NONE     = 8'h00;
   localparam logic [7:0] PST_V4_TCP   = 8'h01;
   localparam logic [7:0] PST_V4       = 8'h02;
   localparam logic [7:0] PST_ARP      = 8'h03;
   localparam logic [7:0] PST_V4_UDP   = 8'h07;
   localparam logic [7:0] PST_V6_TCP   = 8'h81;
   localparam logic [7:0] PST_V6       = 8'h82;
   localparam logic [7:0] PST_V6_UDP   = 8'h83;
   localparam logic [7:0] PST_VLAN_BIT = 8'h40;

   typedef enum logic [1:0] {
      PS_IDLE    = 2'd0,
      PS_TRANS   = 2'd1,
      PS_DISCARD = 2'd2
   } parse_state_t;

   typedef enum logic [2:0] {
      CS_IDLE  = 3'd0,
      CS_WRITE = 3'd1,
      CS_READ  = 3'd2,
      CS_WAIT  = 3'd3,
      CS_ACK   = 3'd4
   } cfg_state_t;

   // Localbus register map, word index addr[9:2]
   localparam logic [7:0] REG_STATUS = 8'h01;
   localparam logic [7:0] REG_IN_PKT = 8'h03;
   localparam logic [7:0] REG_MD     = 8'h05;
   localparam logic [7:0] REG_PHV    = 8'h07;
   localparam logic [7:0] REG_CACHE  = 8'h09;
   localparam logic [7:0] REG_DROP   = 8'h0B;
   localparam logic [7:0] REG_ERR    = 8'h0D;
   localparam logic [7:0] REG_BEATS  = 8'h0F;

   // L3/L4 classification, first match wins
   function automatic logic [7:0] pst_of(input logic [15:0] etype,
                                         input logic [7:0]  v4_proto,
                                         input logic [7:0]  v6_nh);
      logic [7:0] pst;
      pst = PST_NONE;
      if (etype == ETH_IPV6) begin
         if (v6_nh == PROTO_TCP)      pst = PST_V6_TCP;
         else if (v6_nh == PROTO_UDP) pst = PST_V6_UDP;
         else                         pst = PST_V6;
      end else if (etype == ETH_IPV4) begin
         if (v4_proto == PROTO_TCP)      pst = PST_V4_TCP;
         else if (v4_proto == PROTO_UDP) pst = PST_V4_UDP;
         else                            pst = PST_V4;
      end else if (etype == ETH_ARP) begin
         pst = PST_ARP;
      end
      return pst;
   endfunction

endpackage

// File: rtl/gpp_pst_cls.sv
// Combinational packet-type classifier over the top 384 PHV bits (frame byte 0 at MSB).
// Optional macro GPP_VLAN_EN: classify single-tagged frames on the inner EtherType.
module gpp_pst_cls
   import gpp_pkg::*;
(
   input  logic [CLS_W-1:0] i_hdr,
   output logic [7:0]       o_pst
);

   logic [15:0] w_etype;
   logic        w_unused;

   // Frame byte n sits at i_hdr[383-8n -: 8]
   assign w_etype  = i_hdr[287:272];
   assign w_unused = ^i_hdr;

`ifdef GPP_VLAN_EN
   // Tagged frames: inner EtherType at bytes 16-17, L3/L4 fields shifted by 4 bytes
   always_comb begin
      o_pst = pst_of(w_etype, i_hdr[199:192], i_hdr[223:216]);
      if (w_etype == ETH_VLAN) begin
         o_pst = pst_of(i_hdr[255:240], i_hdr[167:160], i_hdr[191:184]) | PST_VLAN_BIT;
      end
   end
`else
   // Untagged classification only; tagged frames fall through to PST_NONE
   assign o_pst = pst_of(w_etype, i_hdr[199:192], i_hdr[223:216]);
`endif

endmodule

// File: rtl/gpp_param.sv
// Parametrised generic packet parser: source filter, 1-cycle forward, MD/PHV build,
// NMID rewrite, missing-tail recovery and a localbus status/counter window.
// Optional macro GPP_VLAN_EN (handled inside gpp_pst_cls).
module gpp_param
   import gpp_pkg::*;
#(
   parameter logic [7:0]  LMID      = 8'd1,
   parameter logic [7:0]  NMID      = 8'd2,
   parameter int unsigned PHV_BEATS = 8,
   parameter logic [7:0]  DROP_LO   = 8'd2,
   parameter logic [7:0]  DROP_HI   = 8'd4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pktin_data_wr,
   input  logic [BEAT_W-1:0]            pktin_data,
   input  logic                         pktin_valid_wr,
   input  logic                         pktin_data_valid,
   output logic                         pktin_ready,
   output logic [PAY_W*PHV_BEATS-1:0]   out_gpp_phv,
   output logic                         out_gpp_phv_wr,
   input  logic                         in_gpp_phv_alf,
   output logic [MD_W-1:0]              out_gpp_md,
   output logic                         out_gpp_md_wr,
   input  logic                         in_gpp_md_alf,
   output logic                         out_gpp_data_wr,
   output logic [BEAT_W-1:0]            out_gpp_data,
   output logic                         out_gpp_valid_wr,
   output logic                         out_gpp_valid,
   input  logic                         in_gpp_data_alf,
   input  logic                         cfg2gpp_cs_n,
   output logic                         gpp2cfg_ack_n,
   input  logic                         cfg2gpp_rw,
   input  logic [31:0]                  cfg2gpp_addr,
   input  logic [31:0]                  cfg2gpp_wdata,
   output logic [31:0]                  gpp2cfg_rdata
);

   localparam int unsigned PHV_W = PAY_W * PHV_BEATS;

   parse_state_t     r_state;
   cfg_state_t       r_cfg_state;
   logic [7:0]       r_step;
   logic [MD_W-1:0]  r_md;
   logic [PHV_W-1:0] r_phv;
   logic [31:0]      r_in_pkt_cnt, r_md_cnt, r_phv_cnt, r_cache_cnt, r_drop_cnt, r_err_cnt;
   logic             r_cs_s1, r_cs_s2;

   logic [1:0]       w_type;
   logic [PAY_W-1:0] w_pay;
   logic             w_drop;
   logic [MD_W-1:0]  w_md_nxt, w_md_out;
   logic [PHV_W-1:0] w_phv_nxt;
   logic [CLS_W-1:0] w_cls_in;
   logic [7:0]       w_pst;
   logic [31:0]      w_rd_mux;
   logic             w_unused;

   assign w_type      = pktin_data[133:132];
   assign w_pay       = pktin_data[PAY_W-1:0];
   assign w_drop      = (w_pay[87:80] >= DROP_LO) && (w_pay[87:80] <= DROP_HI);
   assign pktin_ready = ~(in_gpp_md_alf | in_gpp_phv_alf | in_gpp_data_alf);
   assign w_unused    = ^{cfg2gpp_wdata, cfg2gpp_addr[31:10], cfg2gpp_addr[1:0]};

   // MD/PHV contents including the beat presented this cycle (non-head beats)
   always_comb begin
      w_md_nxt  = r_md;
      w_phv_nxt = r_phv;
      if (r_step == 8'd1) w_md_nxt[MD_W-1:PAY_W] = w_pay;
      for (int unsigned k = 0; k < PHV_BEATS; k++) begin
         if (r_step == 8'(k + 2)) w_phv_nxt[PHV_W-1-PAY_W*k -: PAY_W] = w_pay;
      end
   end

   // Classifier sees the top 384 PHV bits, zero-padded for shallow PHVs
   if (PHV_W >= CLS_W) begin : g_cls_full
      assign w_cls_in = w_phv_nxt[PHV_W-1 -: CLS_W];
   end else begin : g_cls_pad
      assign w_cls_in = {w_phv_nxt, {(CLS_W-PHV_W){1'b0}}};
   end

   gpp_pst_cls u_cls (
      .i_hdr (w_cls_in),
      .o_pst (w_pst)
   );

   // Next-module rewrite when the packet targets this module
   always_comb begin
      w_md_out = w_md_nxt;
      if (w_md_nxt[87:80] == LMID) begin
         w_md_out[87:80] = NMID;
         w_md_out[79:72] = w_pst;
      end
   end

   // Parser FSM: filter, forward, MD/PHV emit, missing-tail recovery, counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= PS_IDLE;
         r_step           <= 8'd0;
         r_md             <= '0;
         r_phv            <= '0;
         r_in_pkt_cnt     <= 32'd0;
         r_md_cnt         <= 32'd0;
         r_phv_cnt        <= 32'd0;
         r_cache_cnt      <= 32'd0;
         r_drop_cnt       <= 32'd0;
         r_err_cnt        <= 32'd0;
         out_gpp_data     <= '0;
         out_gpp_data_wr  <= 1'b0;
         out_gpp_valid_wr <= 1'b0;
         out_gpp_valid    <= 1'b0;
         out_gpp_md       <= '0;
         out_gpp_md_wr    <= 1'b0;
         out_gpp_phv      <= '0;
         out_gpp_phv_wr   <= 1'b0;
      end else begin
         out_gpp_data_wr  <= 1'b0;
         out_gpp_valid_wr <= 1'b0;
         out_gpp_md_wr    <= 1'b0;
         out_gpp_phv_wr   <= 1'b0;
         if (pktin_valid_wr) r_in_pkt_cnt <= r_in_pkt_cnt + 32'd1;
         if (pktin_data_wr) begin
            if (r_state == PS_TRANS) begin
               if (w_type == TYPE_HEAD) begin
                  // Missing tail: close the open packet as bad, drop the new one
                  out_gpp_data     <= {TYPE_TAIL, pktin_data[BEAT_W-3:0]};
                  out_gpp_data_wr  <= 1'b1;
                  out_gpp_valid_wr <= 1'b1;
                  out_gpp_valid    <= 1'b0;
                  r_err_cnt        <= r_err_cnt + 32'd1;
                  r_cache_cnt      <= r_cache_cnt + 32'd1;
                  r_state          <= PS_DISCARD;
               end else begin
                  out_gpp_data    <= pktin_data;
                  out_gpp_data_wr <= 1'b1;
                  r_md            <= w_md_nxt;
                  r_phv           <= w_phv_nxt;
                  if (r_step != 8'hFF) r_step <= r_step + 8'd1;
                  if (w_type == TYPE_TAIL) begin
                     out_gpp_valid_wr <= 1'b1;
                     out_gpp_valid    <= pktin_data_valid;
                     r_cache_cnt      <= r_cache_cnt + 32'd1;
                     r_state          <= PS_IDLE;
                     if (pktin_data_valid) begin
                        out_gpp_md     <= w_md_out;
                        out_gpp_md_wr  <= 1'b1;
                        out_gpp_phv    <= w_phv_nxt;
                        out_gpp_phv_wr <= 1'b1;
                        r_md_cnt       <= r_md_cnt + 32'd1;
                        r_phv_cnt      <= r_phv_cnt + 32'd1;
                     end
                  end
               end
            end else if (w_type == TYPE_HEAD) begin
               if (w_drop) begin
                  r_drop_cnt <= r_drop_cnt + 32'd1;
                  r_state    <= PS_DISCARD;
               end else begin
                  out_gpp_data    <= pktin_data;
                  out_gpp_data_wr <= 1'b1;
                  r_md            <= {{(MD_W-PAY_W){1'b0}}, w_pay};
                  r_phv           <= '0;
                  r_step          <= 8'd1;
                  r_state         <= PS_TRANS;
               end
            end else if (r_state == PS_DISCARD && w_type == TYPE_TAIL) begin
               r_state <= PS_IDLE;
            end
         end
      end
   end

   // Localbus read mux
   always_comb begin
      w_rd_mux = 32'd0;
      case (cfg2gpp_addr[9:2])
         REG_STATUS: w_rd_mux = {r_state, 26'd0, pktin_ready, in_gpp_md_alf,
                                 in_gpp_phv_alf, in_gpp_data_alf};
         REG_IN_PKT: w_rd_mux = r_in_pkt_cnt;
         REG_MD:     w_rd_mux = r_md_cnt;
         REG_PHV:    w_rd_mux = r_phv_cnt;
         REG_CACHE:  w_rd_mux = r_cache_cnt;
         REG_DROP:   w_rd_mux = r_drop_cnt;
         REG_ERR:    w_rd_mux = r_err_cnt;
         REG_BEATS:  w_rd_mux = 32'(PHV_BEATS);
         default:    w_rd_mux = 32'd0;
      endcase
   end

   // Localbus FSM behind a 2-flop cs_n synchroniser; writes are acknowledged and ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_s1       <= 1'b1;
         r_cs_s2       <= 1'b1;
         r_cfg_state   <= CS_IDLE;
         gpp2cfg_ack_n <= 1'b1;
         gpp2cfg_rdata <= 32'd0;
      end else begin
         r_cs_s1 <= cfg2gpp_cs_n;
         r_cs_s2 <= r_cs_s1;
         case (r_cfg_state)
            CS_IDLE: if (!r_cs_s2) r_cfg_state <= cfg2gpp_rw ? CS_READ : CS_WRITE;
            CS_WRITE: begin
               gpp2cfg_ack_n <= 1'b0;
               r_cfg_state   <= CS_ACK;
            end
            CS_READ: begin
               gpp2cfg_rdata <= w_rd_mux;
               r_cfg_state   <= CS_WAIT;
            end
            CS_WAIT: begin
               gpp2cfg_ack_n <= 1'b0;
               r_cfg_state   <= CS_ACK;
            end
            CS_ACK: if (r_cs_s2) begin
               gpp2cfg_ack_n <= 1'b1;
               r_cfg_state   <= CS_IDLE;
            end
            default: r_cfg_state <= CS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpp_param.sv
// Scoreboard bench for gpp_param (PHV_BEATS=2): packet-level reference model feeds
// expectation queues, an independent negedge monitor pops and compares.
module tb_gpp_param;

   localparam int TB_PB = 2;
   localparam int PW    = 128 * TB_PB;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           pktin_data_wr = 1'b0;
   logic [133:0]   pktin_data = '0;
   logic           pktin_valid_wr = 1'b0;
   logic           pktin_data_valid = 1'b0;
   logic           pktin_ready;
   logic [PW-1:0]  out_gpp_phv;
   logic           out_gpp_phv_wr;
   logic           in_gpp_phv_alf = 1'b0;
   logic [255:0]   out_gpp_md;
   logic           out_gpp_md_wr;
   logic           in_gpp_md_alf = 1'b0;
   logic           out_gpp_data_wr;
   logic [133:0]   out_gpp_data;
   logic           out_gpp_valid_wr;
   logic           out_gpp_valid;
   logic           in_gpp_data_alf = 1'b0;
   logic           cfg2gpp_cs_n = 1'b1;
   logic           gpp2cfg_ack_n;
   logic           cfg2gpp_rw = 1'b1;
   logic [31:0]    cfg2gpp_addr = '0;
   logic [31:0]    cfg2gpp_wdata = '0;
   logic [31:0]    gpp2cfg_rdata;

   int n_vec = 0;
   int n_err = 0;
   int m_in_pkt = 0, m_drop = 0, m_err = 0, m_md = 0, m_cache = 0;

   logic [133:0]  q_data[$];
   logic          q_end[$];
   logic [255:0]  q_md[$];
   logic [PW-1:0] q_phv[$];
   logic [127:0]  g_pay [16];

   always #5 clk = ~clk;

   gpp_param #(.PHV_BEATS(TB_PB)) dut (
      .clk(clk), .rst(rst),
      .pktin_data_wr(pktin_data_wr), .pktin_data(pktin_data),
      .pktin_valid_wr(pktin_valid_wr), .pktin_data_valid(pktin_data_valid),
      .pktin_ready(pktin_ready),
      .out_gpp_phv(out_gpp_phv), .out_gpp_phv_wr(out_gpp_phv_wr), .in_gpp_phv_alf(in_gpp_phv_alf),
      .out_gpp_md(out_gpp_md), .out_gpp_md_wr(out_gpp_md_wr), .in_gpp_md_alf(in_gpp_md_alf),
      .out_gpp_data_wr(out_gpp_data_wr), .out_gpp_data(out_gpp_data),
      .out_gpp_valid_wr(out_gpp_valid_wr), .out_gpp_valid(out_gpp_valid),
      .in_gpp_data_alf(in_gpp_data_alf),
      .cfg2gpp_cs_n(cfg2gpp_cs_n), .gpp2cfg_ack_n(gpp2cfg_ack_n), .cfg2gpp_rw(cfg2gpp_rw),
      .cfg2gpp_addr(cfg2gpp_addr), .cfg2gpp_wdata(cfg2gpp_wdata), .gpp2cfg_rdata(gpp2cfg_rdata)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: DUT produced output with nothing expected", nm);
   endtask

   // Frame byte n as captured in the PHV (bytes beyond the packet or PHV read as 0)
   function automatic logic [7:0] fbyte(input int len, input int n);
      int b;
      b = 2 + n / 16;
      if (n >= TB_PB * 16 || b >= len) return 8'h00;
      return g_pay[b][127 - 8 * (n % 16) -: 8];
   endfunction

   function automatic logic [7:0] ref_pst(input int len);
      logic [15:0] et;
      logic [7:0]  p;
      et = {fbyte(len, 12), fbyte(len, 13)};
      if (et == 16'h86DD) begin
         p = fbyte(len, 20);
         return (p == 8'd6) ? 8'h81 : (p == 8'd17) ? 8'h83 : 8'h82;
      end
      if (et == 16'h0800) begin
         p = fbyte(len, 23);
         return (p == 8'd6) ? 8'h01 : (p == 8'd17) ? 8'h07 : 8'h02;
      end
      if (et == 16'h0806) return 8'h03;
      return 8'h00;
   endfunction

   task automatic drive_beat(input logic [1:0] t, input logic [3:0] bv, input logic [127:0] p,
                             input logic vwr, input logic good);
      pktin_data_wr    = 1'b1;
      pktin_data       = {t, bv, p};
      pktin_valid_wr   = vwr;
      pktin_data_valid = good;
      @(posedge clk); #1;
      pktin_data_wr    = 1'b0;
      pktin_valid_wr   = 1'b0;
      pktin_data_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!pktin_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!pktin_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL ready_timeout: pktin_ready still %b after %0d cycles", pktin_ready, n);
      end
   endtask

   // Build a packet, push its expected response, then drive it
   task automatic send_pkt(input int len, input logic [7:0] id, input logic [15:0] et,
                           input logic [7:0] pr, input logic good);
      logic [255:0]  md;
      logic [PW-1:0] phv;
      logic [3:0]    tbv;
      logic [1:0]    t;
      for (int i = 0; i < 16; i++) g_pay[i] = {$urandom, $urandom, $urandom, $urandom};
      g_pay[0][87:80] = id;
      g_pay[2][31:16] = et;
      g_pay[3][95:88] = pr;
      g_pay[3][71:64] = pr;
      tbv = 4'($urandom_range(0, 15));
      m_in_pkt++;
      if (id >= 8'd2 && id <= 8'd4) begin
         m_drop++;
      end else begin
         for (int i = 0; i < len; i++) begin
            t = (i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b11;
            q_data.push_back({t, (i == len - 1) ? tbv : 4'hF, g_pay[i]});
         end
         q_end.push_back(good);
         m_cache++;
         if (good) begin
            md = {g_pay[1], g_pay[0]};
            if (id == 8'd1) begin
               md[87:80] = 8'd2;
               md[79:72] = ref_pst(len);
            end
            phv = '0;
            for (int k = 0; k < TB_PB; k++)
               if (2 + k < len) phv[PW - 1 - 128 * k -: 128] = g_pay[2 + k];
            q_md.push_back(md);
            q_phv.push_back(phv);
            m_md++;
         end
      end
      wait_ready();
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         t = (i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b11;
         drive_beat(t, (i == len - 1) ? tbv : 4'hF, g_pay[i], i == len - 1,
                    (i == len - 1) ? good : 1'b0);
      end
   endtask

   task automatic reg_read(input string nm, input logic [31:0] addr, input logic [31:0] exp,
                           input int exp_lat);
      int lat = 0;
      cfg2gpp_cs_n = 1'b0;
      cfg2gpp_rw   = 1'b1;
      cfg2gpp_addr = addr;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (gpp2cfg_ack_n && lat < 40);
      if (gpp2cfg_ack_n) begin
         unexpected({nm, "_ack_timeout"});
      end else begin
         chk(nm, 256'(gpp2cfg_rdata), 256'(exp));
         if (exp_lat > 0) chk("ack_latency", 256'(lat), 256'(exp_lat));
      end
      cfg2gpp_cs_n = 1'b1;
      lat = 0;
      while (!gpp2cfg_ack_n && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_ack_release"}, 256'(gpp2cfg_ack_n), 256'(1));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int w = 0;
      while ((q_data.size() + q_end.size() + q_md.size() + q_phv.size()) != 0 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("q_data_left", 256'(q_data.size()), 256'(0));
      chk("q_end_left", 256'(q_end.size()), 256'(0));
      chk("q_md_left", 256'(q_md.size() + q_phv.size()), 256'(0));
   endtask

   // Monitor: compare every DUT output strobe against the queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (out_gpp_data_wr === 1'b1) begin
            if (q_data.size() == 0) unexpected("data_beat");
            else chk("data_beat", 256'(out_gpp_data), 256'(q_data.pop_front()));
         end
         if (out_gpp_valid_wr === 1'b1) begin
            if (q_end.size() == 0) unexpected("pkt_end");
            else chk("pkt_end_valid", 256'(out_gpp_valid), 256'(q_end.pop_front()));
         end
         if (out_gpp_md_wr === 1'b1) begin
            chk("md_with_end", 256'(out_gpp_valid_wr), 256'(1));
            if (q_md.size() == 0) unexpected("md");
            else chk("md", out_gpp_md, q_md.pop_front());
         end
         if (out_gpp_phv_wr === 1'b1) begin
            if (q_phv.size() == 0) unexpected("phv");
            else chk("phv", 256'(out_gpp_phv), 256'(q_phv.pop_front()));
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] a, b, c;
      logic [15:0]  et;
      logic [7:0]   pr;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_wr", 256'(out_gpp_data_wr), 256'(0));
      chk("rst_data", 256'(out_gpp_data), 256'(0));
      chk("rst_valid_wr", 256'({out_gpp_valid_wr, out_gpp_valid}), 256'(0));
      chk("rst_md", out_gpp_md, 256'(0));
      chk("rst_strobes", 256'({out_gpp_md_wr, out_gpp_phv_wr}), 256'(0));
      chk("rst_phv", 256'(out_gpp_phv), 256'(0));
      chk("rst_ack_n", 256'(gpp2cfg_ack_n), 256'(1));
      chk("rst_rdata", 256'(gpp2cfg_rdata), 256'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed: IPv4/TCP to this module, dropped source, passing source, IPv6/UDP long packet
      send_pkt(4, 8'd1, 16'h0800, 8'd6, 1'b1);
      send_pkt(3, 8'd3, 16'h0800, 8'd6, 1'b1);
      drain();
      reg_read("drop_cnt_first", 32'h2C, 32'd1, 5);
      send_pkt(3, 8'd5, 16'h0806, 8'd0, 1'b1);
      send_pkt(9, 8'd1, 16'h86DD, 8'd17, 1'b1);
      send_pkt(2, 8'd4, 16'h0800, 8'd6, 1'b1);
      send_pkt(5, 8'd2, 16'h86DD, 8'd6, 1'b1);

      // Missing tail: head, body, head -> forced bad tail, second packet discarded
      wait_ready();
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      c = {$urandom, $urandom, $urandom, $urandom};
      a[87:80] = 8'd1;
      c[87:80] = 8'd5;
      q_data.push_back({2'b01, 4'hF, a});
      q_data.push_back({2'b11, 4'hF, b});
      q_data.push_back({2'b10, 4'hF, c});
      q_end.push_back(1'b0);
      m_cache++;
      m_err++;
      m_in_pkt++;
      drive_beat(2'b01, 4'hF, a, 1'b0, 1'b0);
      drive_beat(2'b11, 4'hF, b, 1'b0, 1'b0);
      drive_beat(2'b01, 4'hF, c, 1'b0, 1'b0);
      drive_beat(2'b11, 4'hF, b, 1'b0, 1'b0);
      drive_beat(2'b10, 4'h3, a, 1'b1, 1'b1);
      drain();

      // Almost-full inputs gate pktin_ready combinationally
      in_gpp_md_alf = 1'b1;
      #1 chk("ready_md_alf", 256'(pktin_ready), 256'(0));
      in_gpp_md_alf = 1'b0; in_gpp_phv_alf = 1'b1;
      #1 chk("ready_phv_alf", 256'(pktin_ready), 256'(0));
      in_gpp_phv_alf = 1'b0; in_gpp_data_alf = 1'b1;
      #1 chk("ready_data_alf", 256'(pktin_ready), 256'(0));
      in_gpp_data_alf = 1'b0;
      #1 chk("ready_clear", 256'(pktin_ready), 256'(1));
      @(posedge clk); #1;
      send_pkt(4, 8'd1, 16'h0800, 8'd17, 1'b0);

      // Randomised traffic
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 4))
            0: et = 16'h0800;
            1: et = 16'h86DD;
            2: et = 16'h0806;
            3: et = 16'h8100;
            default: et = 16'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0: pr = 8'd6;
            1: pr = 8'd17;
            default: pr = 8'($urandom);
         endcase
         send_pkt(int'($urandom_range(2, 9)), 8'($urandom_range(0, 6)), et, pr,
                  $urandom_range(0, 3) != 0);
      end
      drain();

      reg_read("status", 32'h04, 32'h0000_0008, 0);
      reg_read("in_pkt_cnt", 32'h0C, 32'(m_in_pkt), 0);
      reg_read("md_cnt", 32'h14, 32'(m_md), 0);
      reg_read("phv_cnt", 32'h1C, 32'(m_md), 0);
      reg_read("cache_cnt", 32'h24, 32'(m_cache), 0);
      reg_read("drop_cnt", 32'h2C, 32'(m_drop), 0);
      reg_read("err_cnt", 32'h34, 32'(m_err), 0);
      reg_read("phv_beats", 32'h3C, 32'd2, 0);
      reg_read("unmapped", 32'h08, 32'd0, 0);

      // Reset mid-packet: outputs clear, trailing beats ignored
      wait_ready();
      a = {$urandom, $urandom, $urandom, $urandom};
      a[87:80] = 8'd1;
      q_data.push_back({2'b01, 4'hF, a});
      q_data.push_back({2'b11, 4'hF, b});
      drive_beat(2'b01, 4'hF, a, 1'b0, 1'b0);
      drive_beat(2'b11, 4'hF, b, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_data_wr", 256'(out_gpp_data_wr), 256'(0));
      chk("midrst_data", 256'(out_gpp_data), 256'(0));
      chk("midrst_md", out_gpp_md, 256'(0));
      rst = 1'b0;
      drive_beat(2'b11, 4'hF, c, 1'b0, 1'b0);
      drive_beat(2'b10, 4'hF, c, 1'b1, 1'b1);
      drain();
      reg_read("post_rst_cache", 32'h24, 32'd0, 0);
      reg_read("post_rst_in_pkt", 32'h0C, 32'd1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gpp_param.md
Name: gpp_param

Overview:
- Parametrised successor of the generic packet parser in fast_um.
- Receives 134-bit FAST packets from CPU or port and filters them by source field.
- Forwards accepted packets one cycle later to data_cache.
- Emits one MD and one PHV per good packet, PHV depth configurable, with corrected NMID rewrite, VLAN-aware classification option, and protocol-error recovery.

Parameters:
- LMID, 8'd1, local module ID; MD[87:80] match triggers rewrite.
- NMID, 8'd2, next module ID written into MD[87:80] on match.
- PHV_BEATS, 8, PHV depth in 128-bit beats; legal 2..8.
- DROP_LO, 8'd2, lowest first-beat [87:80] value dropped.
- DROP_HI, 8'd4, highest first-beat [87:80] value dropped; DROP_LO<=DROP_HI.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- pktin_data_wr  in  1  beat strobe.
- pktin_data  in  134  [133:132] 01 head / 11 body / 10 tail; [131:128] byte-valid; [127:0] payload.
- pktin_valid_wr  in  1  packet-valid strobe, tail cycle.
- pktin_data_valid  in  1  packet good flag.
- pktin_ready  out  1  ~(in_gpp_md_alf|in_gpp_phv_alf|in_gpp_data_alf).
- out_gpp_phv  out  128*PHV_BEATS  parsed header vector, frame byte 0 at MSB.
- out_gpp_phv_wr  out  1  PHV strobe.
- in_gpp_phv_alf  in  1  PHV almost-full.
- out_gpp_md  out  256  metadata.
- out_gpp_md_wr  out  1  MD strobe.
- in_gpp_md_alf  in  1  MD almost-full.
- out_gpp_data_wr / out_gpp_data  out  1 / 134  forwarded beats.
- out_gpp_valid_wr / out_gpp_valid  out  1 / 1  packet end strobe / good flag.
- in_gpp_data_alf  in  1  data almost-full.
- cfg2gpp_cs_n  in  1  localbus select, low active.
- gpp2cfg_ack_n  out  1  localbus ack, low active.
- cfg2gpp_rw  in  1  0 write, 1 read.
- cfg2gpp_addr / cfg2gpp_wdata  in  32 / 32  localbus address / write data.
- gpp2cfg_rdata  out  32  localbus read data.

Behaviour:
- Reset values:
  - All outputs 0, except gpp2cfg_ack_n=1.
  - State IDLE; all counters, MD, PHV and step counter 0.
  - Reset mid-packet abandons the packet; remaining non-head beats are ignored in IDLE.
- States: IDLE, TRANS, DISCARD.
- IDLE, on head beat:
  - If pktin_data[87:80] is in [DROP_LO,DROP_HI], go to DISCARD and increment drop_cnt.
  - Otherwise forward the beat and go to TRANS.
- TRANS:
  - Forward every beat with 1-cycle latency.
  - Tail → out_gpp_valid_wr=1, out_gpp_valid=pktin_data_valid, return to IDLE.
- DISCARD: nothing forwarded; tail → IDLE.
- Head beat while in TRANS (missing tail):
  - Emit that cycle's beat with type forced to 2'b10, plus out_gpp_valid_wr=1, out_gpp_valid=0.
  - No MD/PHV for the aborted packet; increment err_cnt.
  - The new head is discarded; go to DISCARD.
- Head beat while in DISCARD: apply the normal IDLE head decision.
- Step counter:
  - 0 on head, +1 per beat, saturates at 255.
  - Beats 0–1 fill MD[127:0] and MD[255:128].
  - Beats 2..PHV_BEATS+1 fill PHV, top-down.
  - PHV is cleared on head, so short packets leave trailing beats 0.
- MD/PHV emit:
  - Both strobe together, in the same cycle as out_gpp_valid_wr, only if TRANS and pktin_data_valid=1.
  - Exactly one of each per good packet.
- PST computed from the final PHV in the tail cycle. Priority, first match wins:
  - IPv6 TCP 0x81; IPv6 UDP 0x83; IPv6 0x82.
  - IPv4 TCP 0x01; IPv4 UDP 0x07; IPv4 0x02.
  - ARP 0x03; else 0x00 (no carry-over).
  - EtherType at frame bytes 12–13; IPv4 proto at byte 23; IPv6 next-header at byte 20.
- MD rewrite: if MD[87:80]==LMID, then MD[87:80]←NMID and MD[79:72]←PST; otherwise MD unchanged.
- Backpressure: pktin_ready is combinational. Upstream only starts a packet while ready; the block never stalls mid-packet.
- Localbus:
  - cs_n goes through a 2-flop synchroniser.
  - FSM IDLE→WRITE/READ(→WAIT)→ACK. ACK holds ack_n=0 while cs is asserted, then returns to IDLE.
  - Writes are ignored.
  - Read map, addr[9:2]:
    - 0x1 status {state[1:0],26'b0,ready,md_alf,phv_alf,data_alf}
    - 0x3 in_pkt_cnt (pktin_valid_wr)
    - 0x5 md_cnt
    - 0x7 phv_cnt
    - 0x9 cache_cnt (out_gpp_valid_wr)
    - 0xB drop_cnt
    - 0xD err_cnt
    - 0xF PHV_BEATS
    - others 0
- Counters are 32-bit and wrap.

Optional Feature:
- Macro GPP_VLAN_EN.
- Defined:
  - If bytes 12–13 == 0x8100, classify on inner EtherType at bytes 16–17.
  - L3/L4 offsets shift by +4 bytes.
  - PST[6] is set for tagged frames.
- Undefined: tagged frames give PST 0x00; no extra logic.

Decomposition:
- Package gpp_pkg:
  - Beat type codes HEAD/BODY/TAIL.
  - ETH_IPV4/IPV6/ARP/VLAN constants; PROTO_TCP/UDP constants.
  - PST codes.
  - Parser and cfg state enums.
  - Register address constants.
- One sub-module: gpp_pst_cls, a combinational classifier (PHV top 384 bits → PST), containing the GPP_VLAN_EN logic.
- Synchroniser: existing sync_sig.

Test Plan:
- Good IPv4/TCP packet, 4 beats, [87:80]=1 → 4 beats forwarded at +1 cycle; valid_wr=1 valid=1; MD[87:80]=0x02, MD[79:72]=0x01; phv_wr once.
- Head [87:80]=3 → no data out; drop_cnt=1; next packet [87:80]=5 passes.
- IPv6 UDP packet with PHV_BEATS=2, 9 beats total → PHV holds beats 2–3; PST=0x83; beats 4–8 forwarded only.
- Head, body, then head again → forced tail with type 10, valid=0; err_cnt=1; no MD/PHV; second packet discarded until its tail.
- in_gpp_md_alf=1 → pktin_ready=0 same cycle; bad packet (pktin_data_valid=0) → valid_wr=1 valid=0, md_cnt unchanged.
- Localbus read addr 0x2C → ack_n low after sync+3 cycles, rdata=drop_cnt; rst asserted mid-packet → all outputs 0 next cycle, trailing beats ignored.
